// File: rtl/inert_seq_gen.sv
// Inertial-sensor sequencer: power-up wait, init-table writes and interrupt-driven
// channel bursts over a 16-bit SPI master handshake, with timeout and re-init recovery.
module inert_seq_gen #(
  parameter int                   N_CH       = 2,
  parameter logic [N_CH*8-1:0]    CH_ADDR    = {8'h2C, 8'h22},
  parameter int                   N_INIT     = 4,
  parameter logic [N_INIT*16-1:0] INIT_CMDS  = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
  parameter int                   PWRUP_BITS = 16,
  parameter int                   TMO_BITS   = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 INT,
  input  logic                 reinit,
  input  logic                 done,
  input  logic [15:0]          rd_data,
  output logic                 wrt,
  output logic [15:0]          cmd,
  output logic [N_CH*16-1:0]   data,
  output logic                 vld,
  output logic                 busy,
  output logic                 tmo,
  output logic                 init_done
);

  typedef enum logic [2:0] {PWRUP, INIT_WR, INIT_WT, IDLE, RD_WR, RD_WT} state_t;

  localparam logic [3:0] K_LAST = 4'(N_INIT - 1);
  localparam logic [3:0] J_LAST = 4'(2 * N_CH - 1);

  state_t                state_q, state_d;
  logic [PWRUP_BITS-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [TMO_BITS-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [3:0]            k_q, k_d, j_q, j_d;
  logic                  int_meta_q, int_sync_q;
  logic                  pend_q, pend_d;
  logic                  wrt_q, wrt_d;
  logic [15:0]           cmd_q, cmd_d;
  logic [N_CH*16-1:0]    data_q, data_d, shad_q, shad_d;
  logic                  vld_q, vld_d, tmo_q, tmo_d, init_done_q, init_done_d;
  logic [15:0]           init_cmd;
  logic [7:0]            rd_addr;
  logic                  unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = '0;
    tmo_cnt_d   = '0;
    k_d         = k_q;
    j_d         = j_q;
    pend_d      = pend_q | reinit;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    shad_d      = shad_q;
    data_d      = data_q;
    vld_d       = 1'b0;
    tmo_d       = tmo_q;
    init_done_d = init_done_q;
    init_cmd    = '0;
    rd_addr     = '0;

    case (state_q)
      PWRUP: begin
        pend_d    = 1'b0;
        pwr_cnt_d = pwr_cnt_q + 1'b1;
        if (pwr_cnt_d == '1) begin
          pwr_cnt_d = '0;
          k_d       = '0;
          state_d   = INIT_WR;
        end
      end
      INIT_WR: begin
        pend_d  = 1'b0;
        state_d = INIT_WT;
      end
      INIT_WT: begin
        pend_d = 1'b0;
        if (done) begin
          if (k_q == K_LAST) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = INIT_WR;
          end
        end
      end
      IDLE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (int_sync_q) begin
          tmo_cnt_d = '0;
          j_d       = '0;
          state_d   = RD_WR;
        end else if (pend_q) begin
          tmo_cnt_d   = '0;
          pend_d      = 1'b0;
          init_done_d = 1'b0;
          state_d     = PWRUP;
        end else if (tmo_cnt_d == '1) begin
          tmo_cnt_d   = '0;
          tmo_d       = 1'b1;
          init_done_d = 1'b0;
          state_d     = PWRUP;
        end
      end
      RD_WR: begin
        state_d = RD_WT;
      end
      RD_WT: begin
        if (done) begin
          for (int i = 0; i < 2 * N_CH; i++)
            if (j_q == 4'(i)) shad_d[8*i +: 8] = rd_data[7:0];
          if (j_q == J_LAST) begin
            // final byte is bypassed straight from rd_data into the snapshot
            data_d  = shad_d;
            vld_d   = 1'b1;
            state_d = IDLE;
          end else begin
            j_d     = j_q + 4'd1;
            state_d = RD_WR;
          end
        end
      end
      default: state_d = PWRUP;
    endcase

    for (int i = 0; i < N_INIT; i++)
      if (k_d == 4'(i)) init_cmd = INIT_CMDS[16*i +: 16];
    for (int c = 0; c < N_CH; c++)
      if (j_d[3:1] == 3'(c)) rd_addr = CH_ADDR[8*c +: 8];
    rd_addr = rd_addr + {7'b0, j_d[0]};

    // wrt/cmd are launched on the edge that enters a write state
    if (state_d == INIT_WR) begin
      wrt_d = 1'b1;
      cmd_d = init_cmd;
    end else if (state_d == RD_WR) begin
      wrt_d = 1'b1;
      cmd_d = {1'b1, rd_addr[6:0], 8'h00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      pwr_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      k_q         <= '0;
      j_q         <= '0;
      int_meta_q  <= 1'b0;
      int_sync_q  <= 1'b0;
      pend_q      <= 1'b0;
      wrt_q       <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      tmo_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      k_q         <= k_d;
      j_q         <= j_d;
      int_meta_q  <= INT;
      int_sync_q  <= int_meta_q;
      pend_q      <= pend_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      tmo_q       <= tmo_d;
      init_done_q <= init_done_d;
    end
  end

  // shadow bytes are always fully rewritten before use, so no reset
  always_ff @(posedge clk) begin
    shad_q <= shad_d;
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign vld       = vld_q;
  assign busy      = (state_q != IDLE);
  assign tmo       = tmo_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_inert_seq_gen.sv
// Bench for inert_seq_gen: SPI slave/sensor register model, table and random bursts,
// plus hand sequences for power-up, back-to-back, reinit, timeout and async reset.
module tb_inert_seq_gen;
  localparam int                   N_CH       = 2;
  localparam int                   N_INIT     = 4;
  localparam int                   PWRUP_BITS = 4;
  localparam int                   TMO_BITS   = 6;
  localparam logic [N_CH*8-1:0]    CH_ADDR    = {8'h2C, 8'h22};
  localparam logic [N_INIT*16-1:0] INIT_CMDS  = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

  logic              clk;
  logic              rst_n, INT, reinit, done;
  logic [15:0]       rd_data;
  logic              wrt, vld, busy, tmo, init_done;
  logic [15:0]       cmd;
  logic [N_CH*16-1:0] data;

  int n_vec = 0;
  int n_err = 0;
  int vld_cnt = 0;
  logic [7:0]  regmap [128];
  logic [15:0] cmd_log [$];

  inert_seq_gen #(
    .N_CH(N_CH), .CH_ADDR(CH_ADDR), .N_INIT(N_INIT), .INIT_CMDS(INIT_CMDS),
    .PWRUP_BITS(PWRUP_BITS), .TMO_BITS(TMO_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .reinit(reinit), .done(done),
    .rd_data(rd_data), .wrt(wrt), .cmd(cmd), .data(data), .vld(vld),
    .busy(busy), .tmo(tmo), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI master + sensor model: done clears on the wrt cycle, rises after a random latency
  initial begin
    int cnt;
    logic [6:0] addr;
    cnt = 0;
    addr = '0;
    done = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done = 1'b0;
        cnt = 0;
      end else if (wrt) begin
        done = 1'b0;
        cmd_log.push_back(cmd);
        addr = cmd[14:8];
        cnt = int'($urandom_range(1, 3));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          rd_data = {8'($urandom), regmap[addr]};
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (vld) vld_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // expected values straight from the register-map rules
  function automatic logic [15:0] exp_cmd(input int i);
    logic [N_CH*8-1:0] addrs;
    logic [7:0] a;
    addrs = CH_ADDR;
    a = addrs[8*(i/2) +: 8] + 8'(i % 2);
    return {1'b1, a[6:0], 8'h00};
  endfunction

  function automatic logic [N_CH*16-1:0] exp_snap();
    logic [N_CH*8-1:0] addrs;
    logic [N_CH*16-1:0] r;
    logic [7:0] a, lo, hi;
    addrs = CH_ADDR;
    r = '0;
    for (int c = 0; c < N_CH; c++) begin
      a  = addrs[8*c +: 8];
      lo = regmap[a[6:0]];
      a  = a + 8'd1;
      hi = regmap[a[6:0]];
      r  = r | ((N_CH*16)'({hi, lo}) << (16 * c));
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_init(input int i);
    logic [N_INIT*16-1:0] t;
    t = INIT_CMDS;
    return t[16*i +: 16];
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " wrt"},       64'(wrt),       64'd0);
    chk({tag, " cmd"},       64'(cmd),       64'd0);
    chk({tag, " data"},      64'(data),      64'd0);
    chk({tag, " vld"},       64'(vld),       64'd0);
    chk({tag, " busy"},      64'(busy),      64'd1);
    chk({tag, " tmo"},       64'(tmo),       64'd0);
    chk({tag, " init_done"}, 64'(init_done), 64'd0);
  endtask

  // call from the first sample in PWRUP (counter at 0); returns on first IDLE sample
  task automatic check_powerup(input string tag);
    int first;
    int base;
    first = -1;
    base = cmd_log.size();
    for (int e = 1; e <= 300 && !init_done; e++) begin
      step();
      if (wrt && first < 0) begin
        first = e;
        chk({tag, " first cmd"}, 64'(cmd), 64'h0D02);
      end
    end
    chk({tag, " first wrt cycle"}, 64'(first), 64'd15);
    chk({tag, " init_done"}, 64'(init_done), 64'd1);
    chk({tag, " init count"}, 64'(cmd_log.size() - base), 64'(N_INIT));
    for (int i = 0; i < N_INIT; i++)
      if (base + i < cmd_log.size())
        chk({tag, " init cmd"}, 64'(cmd_log[base+i]), 64'(exp_init(i)));
  endtask

  task automatic wait_vld(input string tag, input int maxc, output logic [N_CH*16-1:0] d);
    bit got;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (vld) begin
        got = 1'b1;
        d = data;
      end
    end
    chk({tag, " vld seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_wrt(input string tag, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (wrt) got = 1'b1;
    end
    chk({tag, " wrt seen"}, 64'(got), 64'd1);
  endtask

  task automatic run_burst(input string tag, input logic [N_CH*16-1:0] exp);
    int base;
    int vbase;
    logic [N_CH*16-1:0] d;
    base = cmd_log.size();
    vbase = vld_cnt;
    INT = 1'b1;
    wait_wrt(tag, 50);
    INT = 1'b0;
    wait_vld(tag, 200, d);
    chk({tag, " data"}, 64'(d), 64'(exp));
    chk({tag, " ncmd"}, 64'(cmd_log.size() - base), 64'(2 * N_CH));
    for (int i = 0; i < 2 * N_CH; i++)
      if (base + i < cmd_log.size())
        chk({tag, " rd cmd"}, 64'(cmd_log[base+i]), 64'(exp_cmd(i)));
    repeat (3) step();
    chk({tag, " held"}, 64'(data), 64'(exp));
    chk({tag, " vld pulses"}, 64'(vld_cnt - vbase), 64'd1);
  endtask

  typedef struct {
    logic [7:0]         b0, b1, b2, b3;
    logic [N_CH*16-1:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [4];
    logic [N_CH*16-1:0] d, last, e1, e2;
    int t;
    int vbase;

    tbl[0] = '{b0: 8'h34, b1: 8'h12, b2: 8'hCD, b3: 8'hAB, exp: 32'hABCD_1234};
    tbl[1] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp: 32'h0000_0000};
    tbl[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF, exp: 32'hFFFF_FFFF};
    tbl[3] = '{b0: 8'h01, b1: 8'h80, b2: 8'h7F, b3: 8'hFE, exp: 32'hFE7F_8001};

    for (int i = 0; i < 128; i++) regmap[i] = 8'($urandom);
    rst_n = 1'b0;
    INT = 1'b0;
    reinit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_powerup("pwrup");

    // table-driven bursts
    for (int v = 0; v < 4; v++) begin
      regmap[7'h22] = tbl[v].b0;
      regmap[7'h23] = tbl[v].b1;
      regmap[7'h2C] = tbl[v].b2;
      regmap[7'h2D] = tbl[v].b3;
      run_burst($sformatf("tbl%0d", v), tbl[v].exp);
    end

    // random register contents against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 128; i++) regmap[i] = 8'($urandom);
      run_burst($sformatf("rand%0d", r), exp_snap());
    end

    // back-to-back: INT held high across the end of a burst
    e1 = exp_snap();
    vbase = vld_cnt;
    INT = 1'b1;
    wait_vld("b2b1", 200, d);
    chk("b2b1 data", 64'(d), 64'(e1));
    chk("b2b1 busy in IDLE", 64'(busy), 64'd0);
    step();
    chk("b2b next wrt", 64'(wrt), 64'd1);
    chk("b2b next cmd", 64'(cmd), 64'(exp_cmd(0)));
    INT = 1'b0;
    wait_vld("b2b2", 200, d);
    chk("b2b2 data", 64'(d), 64'(e1));
    repeat (3) step();
    chk("b2b vld pulses", 64'(vld_cnt - vbase), 64'd2);

    // reinit during RD_WT: burst completes, then re-init
    for (int i = 0; i < 128; i++) regmap[i] = 8'($urandom);
    e1 = exp_snap();
    INT = 1'b1;
    wait_wrt("ri", 50);
    INT = 1'b0;
    step();
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    wait_vld("ri", 200, d);
    chk("ri data", 64'(d), 64'(e1));
    step();
    chk("ri busy", 64'(busy), 64'd1);
    chk("ri init_done", 64'(init_done), 64'd0);
    chk("ri wrt", 64'(wrt), 64'd0);
    check_powerup("ri pwrup");
    chk("ri data held", 64'(data), 64'(e1));

    // reinit pending but INT wins the first IDLE cycle
    for (int i = 0; i < 128; i++) regmap[i] = 8'($urandom);
    e2 = exp_snap();
    INT = 1'b1;
    wait_wrt("riw", 50);
    step();
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    wait_vld("riw1", 200, d);
    chk("riw1 data", 64'(d), 64'(e2));
    step();
    chk("riw INT wins", 64'(wrt), 64'd1);
    INT = 1'b0;
    wait_vld("riw2", 200, d);
    chk("riw2 data", 64'(d), 64'(e2));
    step();
    chk("riw pending busy", 64'(busy), 64'd1);
    chk("riw pending init_done", 64'(init_done), 64'd0);
    check_powerup("riw pwrup");
    last = e2;

    // interrupt timeout
    chk("tmo before", 64'(tmo), 64'd0);
    t = 0;
    while (!tmo && t < 200) begin
      step();
      t++;
    end
    chk("tmo cycle", 64'(t), 64'd63);
    chk("tmo init_done", 64'(init_done), 64'd0);
    chk("tmo data held", 64'(data), 64'(last));
    check_powerup("tmo pwrup");
    chk("tmo sticky", 64'(tmo), 64'd1);

    // reinit from IDLE, then async reset mid INIT_WT
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    wait_wrt("rst", 40);
    chk("rst init cmd", 64'(cmd), 64'h0D02);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_powerup("rst pwrup");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inert_seq_gen.md
Name: inert_seq_gen

Overview:
- Parametrised inertial-sensor sequencer. Powers up the sensor, writes a configurable init table over a 16-bit SPI master handshake, then services sensor interrupts by reading N_CH 16-bit channels.
- Channels are read as low/high byte pairs. On each completed burst it presents one registered snapshot of all channels with a one-cycle vld pulse.
- Adds interrupt-timeout recovery with re-init, a software re-init request, and held (non-zeroed) outputs.
- Sits between SPI_mstr16 and the integrator/balance logic.

Parameters:
- N_CH, 2, number of 16-bit channels read per burst (1..8).
- CH_ADDR, {8'h2C,8'h22}, packed N_CH*8 low-byte register addresses; channel i uses bits [8i+7:8i]; high byte is at address+1.
- N_INIT, 4, number of init writes (1..8).
- INIT_CMDS, {16'h1460,16'h1150,16'h1053,16'h0D02}, packed N_INIT*16 write commands, issued entry 0 first.
- PWRUP_BITS, 16, power-up wait of 2^PWRUP_BITS-1 cycles.
- TMO_BITS, 20, IDLE interrupt timeout of 2^TMO_BITS-1 cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- INT  in  1  sensor data-ready, asynchronous; double-flopped internally
- reinit  in  1  one-cycle request to re-run power-up wait and init table
- done  in  1  SPI transaction complete (from SPI master)
- rd_data  in  16  SPI read data; byte [7:0] is used
- wrt  out  1  one-cycle SPI start pulse
- cmd  out  16  SPI command, registered, stable from wrt until done
- data  out  N_CH*16  channel snapshot; channel i = [16i+15:16i]
- vld  out  1  one-cycle pulse when data updates
- busy  out  1  high in any state other than IDLE
- tmo  out  1  sticky flag: interrupt timeout occurred; cleared by reset only
- init_done  out  1  high once the init table has completed; low during (re)init

Behaviour:
- Reset values: wrt=0, cmd=0, data=0, vld=0, busy=1, tmo=0, init_done=0. Async reset at any point aborts any transaction and returns to PWRUP.
- States: PWRUP, INIT_WR, INIT_WT, IDLE, RD_WR, RD_WT.
- PWRUP: counter increments each cycle. When the counter reaches all-ones, go to INIT_WR with index k=0. The counter clears on entry.
- INIT_WR: one cycle. cmd=INIT_CMDS[k], wrt=1, then go to INIT_WT.
- INIT_WT: wait for done.
  - If k<N_INIT-1: k++, go to INIT_WR.
  - Else: init_done=1, go to IDLE.
- Done handshake:
  - The SPI master clears done on the edge sampling wrt.
  - done is not sampled in the wrt cycle.
  - done seen in any other state is ignored.
- IDLE: timeout counter runs.
  - Synced INT=1: go to RD_WR with j=0. Timeout counter clears.
  - Else, timeout counter all-ones: tmo=1, init_done=0, go to PWRUP.
  - INT has priority over timeout in the same cycle.
- reinit:
  - Pulse in any state latches a pending flag.
  - The flag is acted on only in IDLE (priority below INT): go to PWRUP, init_done=0, flag clears.
  - A reinit during PWRUP/INIT is absorbed (flag cleared on PWRUP entry).
- RD_WR: one cycle.
  - Transaction j (0..2*N_CH-1) targets channel c=j>>1, byte b=j[0].
  - cmd={1'b1, (CH_ADDR[c]+b)[6:0], 8'h00}, wrt=1, then go to RD_WT.
- RD_WT: on done, write rd_data[7:0] into shadow byte (c,b).
  - If j<2*N_CH-1: j++, go to RD_WR.
  - Else: copy all shadow bytes to data (the final byte is taken directly from rd_data the same cycle), assert vld for that cycle, go to IDLE.
- Latency: from done of the last read, data and vld update on the next clock edge.
- data holds between bursts and is unchanged by timeout, reinit or re-init.
- Address arithmetic is 8-bit and wraps (0xFF+1=0x00). Bit 7 of the read command is forced to 1.
- INT still high on return to IDLE starts a new burst in the next cycle.
- busy=0 only in IDLE.

Test Plan:
- Power-up/init (PWRUP_BITS=4): release reset → first wrt at cycle 15 with cmd=0x0D02. Later writes are 0x1053, 0x1150, 0x1460, each issued after done. init_done rises after the 4th done; no wrt before cycle 15.
- Read burst (N_CH=2): INT high, model returns bytes 0x34,0x12,0xCD,0xAB → cmds 0xA200,0xA300,0xAC00,0xAD00 in order. data=0xABCD_1234, vld high exactly one cycle, data held afterwards.
- Back-to-back: INT held high → second burst's first wrt occurs 1 cycle after entering IDLE. vld pulses once per burst.
- Timeout (TMO_BITS=6): no INT after init → tmo=1 at count 63, init_done=0, full init table re-sent. data keeps its last value.
- reinit during RD_WT → current burst completes with vld. Next cycle in IDLE goes to PWRUP; INT arriving the same cycle wins instead, with reinit pending until the next IDLE.
- Async reset asserted mid-INIT_WT → all outputs return to reset values immediately, and the sequence restarts from PWRUP.
